// File: rtl/plic_gw_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway.
package plic_gw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    CLAIMED = 2'd2
  } gw_state_t;

  function automatic int src_id(input int i);
    return i + 1;
  endfunction

endpackage

// File: rtl/plic_gateway_src.sv
// One gateway source: 2-flop sync, rise detect, saturating edge counter, IDLE/REQ/CLAIMED FSM.
// Level: req 2 cycles after the line is sampled high. Edge: cnt after 2 cycles, req after 3.
module plic_gateway_src
  import plic_gw_pkg::*;
#(
  parameter int SRC_ID = 1,
  parameter int CNT_W  = 2,
  parameter int ID_W   = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            irq_src,
  input  logic            edge_mode,
  input  logic            claim_valid,
  input  logic [ID_W-1:0] claim_id,
  input  logic            complete_valid,
  input  logic [ID_W-1:0] complete_id,
  output logic            req,
  output logic            in_service,
  output logic            overflow
);

  localparam logic [ID_W-1:0]  MY_ID   = ID_W'(SRC_ID);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s2_prev_q, s2_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gw_state_t        state_q, state_d;
  logic             req_q, req_d;
  logic             in_service_q, in_service_d;
  logic             overflow_q, overflow_d;

  logic rise;
  logic claim_hit;
  logic complete_hit;

  always_comb begin
    s1_d      = irq_src;
    s2_d      = s1_q;
    s2_prev_d = s2_q;

    rise         = s2_q & ~s2_prev_q;
    claim_hit    = claim_valid && (claim_id == MY_ID) && (state_q == REQ);
    complete_hit = complete_valid && (complete_id == MY_ID) && (state_q == CLAIMED);

    // A rise coinciding with a claim cancels out, so cnt holds in that case.
    cnt_d      = cnt_q;
    overflow_d = 1'b0;
    if (!edge_mode) begin
      cnt_d = '0;
    end else begin
      overflow_d = rise && (cnt_q == CNT_MAX);
      if (rise && !claim_hit) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (!rise && claim_hit && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_mode ? (cnt_q != '0) : s2_q) state_d = REQ;
      REQ:     if (claim_hit) state_d = CLAIMED;
      CLAIMED: if (complete_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_d        = (state_d == REQ);
    in_service_d = (state_d == CLAIMED);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s2_prev_q    <= 1'b0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      req_q        <= 1'b0;
      in_service_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s2_prev_q    <= s2_prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      req_q        <= req_d;
      in_service_q <= in_service_d;
      overflow_q   <= overflow_d;
    end
  end

  assign req        = req_q;
  assign in_service = in_service_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/plic_gateway.sv
// Array of per-source interrupt gateways feeding the PLIC pending inputs.
// Stateless wrapper: source i answers to claim/complete ID i+1.
module plic_gateway
  import plic_gw_pkg::*;
#(
  parameter int N_interrupts = 32,
  parameter int CNT_W        = 2,
  parameter int ID_W         = $clog2(N_interrupts + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_interrupts-1:0] irq_src,
  input  logic [N_interrupts-1:0] edge_mode,
  input  logic                    claim_valid,
  input  logic [ID_W-1:0]         claim_id,
  input  logic                    complete_valid,
  input  logic [ID_W-1:0]         complete_id,
  output logic [N_interrupts-1:0] req,
  output logic [N_interrupts-1:0] in_service,
  output logic [N_interrupts-1:0] overflow
);

  for (genvar i = 0; i < N_interrupts; i++) begin : g_src
    plic_gateway_src #(
      .SRC_ID (src_id(i)),
      .CNT_W  (CNT_W),
      .ID_W   (ID_W)
    ) u_src (
      .clk            (clk),
      .n_rst          (n_rst),
      .irq_src        (irq_src[i]),
      .edge_mode      (edge_mode[i]),
      .claim_valid    (claim_valid),
      .claim_id       (claim_id),
      .complete_valid (complete_valid),
      .complete_id    (complete_id),
      .req            (req[i]),
      .in_service     (in_service[i]),
      .overflow       (overflow[i])
    );
  end

endmodule
